// File: rtl/motor_pkg.sv
// Shared definitions for the motor command conditioner: control FSM state
// encoding and the default timing constants for a 27 MHz system clock.
package motor_pkg;

  // 10 ms of stable input before a button change is accepted.
  localparam int DEBOUNCE_CYCLES_DEFAULT = 270000;
  // 50 ms run-off pause before reversing a running motor.
  localparam int DWELL_CYCLES_DEFAULT = 1350000;

  typedef enum logic [1:0] {
    ST_STOPPED = 2'd0,
    ST_RUNNING = 2'd1,
    ST_DWELL   = 2'd2
  } motor_state_t;

endpackage

// File: rtl/btn_debounce.sv
// One raw active-low button: 2-flop synchronizer, saturating debounce
// counter, debounced stable level and a one-cycle press pulse on the
// stable 1->0 transition. After reset the button must first be seen
// released for a full debounce window before any press is accepted, so a
// button held through reset produces nothing until released and re-pressed.
module btn_debounce
  import motor_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  logic          sync1;
  logic          sync2;
  logic          level;
  logic          armed;
  logic [CW-1:0] cnt;
  logic          differ;

  // Disarmed: count consecutive released cycles. Armed: count cycles where
  // the synchronized input disagrees with the stable level.
  assign differ = armed ? (sync2 != level) : sync2;

  // Bring the asynchronous button into the clk domain; idle level is released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
    end
  end

  // Debounce counter, stable level, arming and registered press pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      level <= 1'b1;
      armed <= 1'b0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      if (!differ) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt <= '0;
        if (armed) begin
          level <= sync2;
          press <= ~sync2;
        end else begin
          armed <= 1'b1;
        end
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/motor_cmd_conditioner.sv
// Turns three raw push buttons into registered motor commands: run,
// direction, speed select, and a busy flag while a running reversal pauses
// for the run-off dwell. The direction output only ever changes while the
// coils are off.
module motor_cmd_conditioner
  import motor_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int DWELL_CYCLES    = DWELL_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start_stop_n,
  input  logic       btn_direction_n,
  input  logic       btn_speed_n,
  output logic       run,
  output logic       direction,
  output logic       speed_sel,
  output logic       dir_busy,
  output logic [1:0] state_dbg
);

  localparam int DW = $clog2(DWELL_CYCLES + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);

  logic          start_p;
  logic          dir_p;
  logic          speed_p;

  motor_state_t  state;
  motor_state_t  state_nx;
  logic          dir_nx;
  logic [DW-1:0] dwell_cnt;
  logic [DW-1:0] dwell_nx;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
    .clk   (clk),
    .rst   (rst),
    .btn_n (btn_start_stop_n),
    .press (start_p)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dir (
    .clk   (clk),
    .rst   (rst),
    .btn_n (btn_direction_n),
    .press (dir_p)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_speed (
    .clk   (clk),
    .rst   (rst),
    .btn_n (btn_speed_n),
    .press (speed_p)
  );

  assign state_dbg = state;

  // Next-state logic; a start press always takes priority over a direction press.
  always_comb begin
    state_nx = state;
    dir_nx   = direction;
    dwell_nx = dwell_cnt;
    case (state)
      ST_STOPPED: begin
        if (start_p) begin
          state_nx = ST_RUNNING;
        end else if (dir_p) begin
          dir_nx = ~direction;
        end
      end
      ST_RUNNING: begin
        if (start_p) begin
          state_nx = ST_STOPPED;
        end else if (dir_p) begin
          state_nx = ST_DWELL;
          dwell_nx = '0;
        end
      end
      ST_DWELL: begin
        if (start_p) begin
          // Stopping mid-dwell still commits the reversal the user asked for.
          dir_nx   = ~direction;
          state_nx = ST_STOPPED;
        end else if (dwell_cnt == DWELL_LAST) begin
          dir_nx   = ~direction;
          state_nx = ST_RUNNING;
        end else begin
          dwell_nx = dwell_cnt + 1'b1;
        end
      end
      default: begin
        state_nx = ST_STOPPED;
      end
    endcase
  end

  // State, dwell counter and registered outputs derived from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_STOPPED;
      dwell_cnt <= '0;
      direction <= 1'b0;
      speed_sel <= 1'b0;
      run       <= 1'b0;
      dir_busy  <= 1'b0;
    end else begin
      state     <= state_nx;
      dwell_cnt <= dwell_nx;
      direction <= dir_nx;
      speed_sel <= speed_sel ^ speed_p;
      run       <= (state_nx == ST_RUNNING);
      dir_busy  <= (state_nx == ST_DWELL);
    end
  end

endmodule

// File: tb/tb_motor_cmd_conditioner.sv
// Bench for motor_cmd_conditioner with short debounce/dwell windows.
module tb_motor_cmd_conditioner;
  import motor_pkg::*;

  localparam int DEB = 4;
  localparam int DWL = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       bs  = 1'b1;
  logic       bd  = 1'b1;
  logic       bsp = 1'b1;
  logic       run;
  logic       direction;
  logic       speed_sel;
  logic       dir_busy;
  logic [1:0] state_dbg;

  motor_cmd_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .DWELL_CYCLES   (DWL)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .btn_start_stop_n (bs),
    .btn_direction_n  (bd),
    .btn_speed_n      (bsp),
    .run              (run),
    .direction        (direction),
    .speed_sel        (speed_sel),
    .dir_busy         (dir_busy),
    .state_dbg        (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int test_count = 0;
  int fail_count = 0;
  logic [3:0] exp_q[$];

  function automatic logic [3:0] obs();
    return {run, direction, speed_sel, dir_busy};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_push(input logic [3:0] e);
    exp_q.push_back(e);
  endtask

  task automatic check_pop(input string name);
    logic [3:0] e;
    test_count++;
    if (exp_q.size() == 0) begin
      fail_count++;
      $display("FAIL %s: scoreboard empty, got {run,dir,spd,busy}=%b", name, obs());
    end else begin
      e = exp_q.pop_front();
      if (obs() !== e) begin
        fail_count++;
        $display("FAIL %s: got {run,dir,spd,busy}=%b, expected %b", name, obs(), e);
      end
    end
  endtask

  task automatic check_val(input string name, input int actual, input int expected);
    test_count++;
    if (actual != expected) begin
      fail_count++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // ---------------- driver ----------------
  // mask = {start, direction, speed}; a set bit holds that button pressed.
  task automatic drive(input logic [2:0] mask, input int hold, input int settle);
    bs  = ~mask[2];
    bd  = ~mask[1];
    bsp = ~mask[0];
    tick(hold);
    bs  = 1'b1;
    bd  = 1'b1;
    bsp = 1'b1;
    tick(settle);
  endtask

  // Direction must never change while run stays high across a cycle.
  logic prev_run = 1'b0;
  logic prev_dir = 1'b0;
  always @(negedge clk) begin
    if (!rst && prev_run && run) begin
      test_count++;
      if (direction !== prev_dir) begin
        fail_count++;
        $display("FAIL dir_while_run: direction %b -> %b with run=1", prev_dir, direction);
      end
    end
    prev_run = run;
    prev_dir = direction;
  end

  typedef struct {
    logic [2:0] press;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int lat;
    int low_cnt;
    int busy_cnt;
    int seen;
    int rise_ok;
    int found;
    logic pr;
    logic pd;

    // {start,dir,speed} pressed -> {run,direction,speed_sel,dir_busy} after settling
    vecs[0] = '{3'b001, 4'b0010};  // speed while stopped
    vecs[1] = '{3'b010, 4'b0110};  // direction while stopped toggles at once
    vecs[2] = '{3'b100, 4'b1110};  // start
    vecs[3] = '{3'b001, 4'b1100};  // speed while running
    vecs[4] = '{3'b010, 4'b1000};  // reversal through dwell
    vecs[5] = '{3'b110, 4'b0000};  // start+dir running: stop, no reversal
    vecs[6] = '{3'b110, 4'b1000};  // start+dir stopped: start, no toggle
    vecs[7] = '{3'b100, 4'b0000};  // stop
    vecs[8] = '{3'b100, 4'b1000};  // start
    vecs[9] = '{3'b111, 4'b0010};  // all three running: stop + speed toggle

    // Reset state
    rst = 1'b1;
    tick(3);
    expect_push(4'b0000);
    check_pop("reset_outputs");
    check_val("reset_state", int'(state_dbg), int'(ST_STOPPED));
    rst = 1'b0;
    tick(10);

    // Table-driven vectors
    for (int i = 0; i < 10; i++) begin
      expect_push(vecs[i].exp);
      drive(vecs[i].press, 10, 12);
      check_pop($sformatf("vec%0d", i));
    end

    // Bounce shorter than the debounce window never registers
    bs = 1'b0; tick(3);
    bs = 1'b1; tick(2);
    bs = 1'b0; tick(3);
    bs = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (run) seen = 1;
    end
    check_val("bounce_no_run", seen, 0);

    // Clean press: 2 sync + 4 debounce + 1 output register
    bs = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      if (run) begin
        lat = i;
        break;
      end
    end
    check_val("start_latency", lat, 7);
    tick(3);
    bs = 1'b1;
    tick(12);
    expect_push(4'b1010);
    check_pop("after_start");

    // Running reversal: run low and busy for exactly DWL cycles
    bd = 1'b0;
    low_cnt = 0;
    busy_cnt = 0;
    rise_ok = 0;
    pr = run;
    pd = direction;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (i == 9) bd = 1'b1;
      if (!run) low_cnt++;
      if (dir_busy) busy_cnt++;
      if (run && !pr) rise_ok = (direction == 1'b1 && pd == 1'b0) ? 1 : 0;
      pr = run;
      pd = direction;
    end
    check_val("dwell_run_low", low_cnt, DWL);
    check_val("dwell_busy", busy_cnt, DWL);
    check_val("dwell_dir_at_rise", rise_ok, 1);
    expect_push(4'b1110);
    check_pop("after_reversal");

    // Speed and start during dwell: stop in dwell cycle 3, reversal committed
    bd = 1'b0;
    tick(2);
    bsp = 1'b0;
    tick(1);
    bs = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      if (i == 8) begin
        bs = 1'b1;
        bd = 1'b1;
        bsp = 1'b1;
      end
      if (dir_busy) busy_cnt++;
    end
    check_val("dwell_abort_busy", busy_cnt, 3);
    expect_push(4'b0000);
    check_pop("stop_in_dwell");

    // Direction press while stopped never touches run or dir_busy
    bd = 1'b0;
    seen = 0;
    for (int i = 0; i < 22; i++) begin
      tick(1);
      if (i == 9) bd = 1'b1;
      if (run || dir_busy) seen = 1;
    end
    check_val("stopped_dir_quiet", seen, 0);
    expect_push(4'b0100);
    check_pop("stopped_dir");
    expect_push(4'b1100);
    drive(3'b100, 10, 12);
    check_pop("restart");
    expect_push(4'b1110);
    drive(3'b001, 10, 12);
    check_pop("speed_up");

    // Reset in dwell cycle 3, direction button still held across reset
    bd = 1'b0;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (dir_busy) begin
        found = 1;
        break;
      end
    end
    check_val("dwell_entered", found, 1);
    tick(2);
    rst = 1'b1;
    tick(1);
    expect_push(4'b0000);
    check_pop("rst_in_dwell");
    tick(2);
    rst = 1'b0;
    tick(3);
    bd = 1'b1;
    tick(15);
    expect_push(4'b0000);
    check_pop("after_rst_dwell");

    // Start held through reset deassertion: nothing until released and re-pressed
    bs = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(20);
    expect_push(4'b0000);
    check_pop("held_through_reset");
    bs = 1'b1;
    tick(12);
    expect_push(4'b0000);
    check_pop("released_after_reset");
    expect_push(4'b1000);
    drive(3'b100, 10, 12);
    check_pop("repress_after_reset");

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
